// File: rtl/la_ioseq.sv
// Power-aware enable sequencer and per-pin config register file for one padring side.
// Releases pin enables one at a time, STEP cycles apart, once io power is good.
module la_ioseq #(
    parameter int unsigned NPINS = 8,
    parameter int unsigned CFGW  = 8,
    parameter int unsigned STEP  = 4
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    pwrgood,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [7:0]              wr_addr,
    input  logic                    wr_ie,
    input  logic                    wr_oe,
    input  logic [CFGW-1:0]         wr_cfg,
    output logic                    wr_err,
    output logic [NPINS-1:0]        ie,
    output logic [NPINS-1:0]        oe,
    output logic [NPINS*CFGW-1:0]   cfg,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IW = (NPINS > 1) ? $clog2(NPINS) : 1;
    localparam int unsigned TW = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(NPINS - 1);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(STEP - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RAMP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_d;
    logic [TW-1:0]           timer;
    logic [TW-1:0]           timer_d;
    logic [NPINS-1:0]        ie_mask;
    logic [NPINS-1:0]        oe_mask;
    logic [NPINS-1:0]        ie_mask_nxt;
    logic [NPINS-1:0]        oe_mask_nxt;
    logic [NPINS*CFGW-1:0]   cfg_nxt;
    logic [NPINS-1:0]        ie_d;
    logic [NPINS-1:0]        oe_d;
    logic [NPINS-1:0]        released;
    logic                    wr_fire;
    logic                    wr_hit;
    logic                    wr_bad;
    logic                    tmr_zero;

    assign wr_ready = nreset;
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_hit   = wr_fire & (32'(wr_addr) < NPINS);
    assign wr_bad   = wr_fire & (32'(wr_addr) >= NPINS);
    assign tmr_zero = (timer == '0);

    // Masks/cfg as they will be after this edge; enables use these so a write
    // landing on a pin's release edge (or in RUN) takes effect immediately.
    always_comb begin
        ie_mask_nxt = ie_mask;
        oe_mask_nxt = oe_mask;
        cfg_nxt     = cfg;
        for (int unsigned p = 0; p < NPINS; p++) begin
            if (wr_hit && (32'(wr_addr) == p)) begin
                ie_mask_nxt[p]           = wr_ie;
                oe_mask_nxt[p]           = wr_oe;
                cfg_nxt[p*CFGW +: CFGW]  = wr_cfg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= S_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:   if (pwrgood) state_nxt = S_RAMP;
            S_RAMP: begin
                if (!pwrgood)                          state_nxt = S_OFF;
                else if (tmr_zero && idx == IDX_LAST)  state_nxt = S_RUN;
            end
            S_RUN:   if (!pwrgood) state_nxt = S_OFF;
            default: state_nxt = S_OFF;
        endcase
    end

    // Pins already released, plus the current pin on its release cycle.
    always_comb begin
        released = '0;
        for (int unsigned p = 0; p < NPINS; p++) begin
            released[p] = (32'(idx) > p) || (tmr_zero && (32'(idx) == p));
        end
    end

    always_comb begin
        ie_d    = ie;
        oe_d    = oe;
        idx_d   = idx;
        timer_d = timer;
        case (state)
            S_OFF: begin
                ie_d  = '0;
                oe_d  = '0;
                idx_d = '0;
                if (pwrgood) timer_d = TMR_RELOAD;
            end
            S_RAMP: begin
                if (!pwrgood) begin
                    ie_d  = '0;
                    oe_d  = '0;
                    idx_d = '0;
                end else begin
                    ie_d = ie_mask_nxt & released;
                    oe_d = oe_mask_nxt & released;
                    if (tmr_zero) begin
                        timer_d = TMR_RELOAD;
                        idx_d   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    end else begin
                        timer_d = timer - TW'(1);
                    end
                end
            end
            S_RUN: begin
                if (!pwrgood) begin
                    ie_d  = '0;
                    oe_d  = '0;
                    idx_d = '0;
                end else begin
                    ie_d = ie_mask_nxt;
                    oe_d = oe_mask_nxt;
                end
            end
            default: begin
                ie_d  = '0;
                oe_d  = '0;
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            idx     <= '0;
            timer   <= '0;
            ie_mask <= '0;
            oe_mask <= '0;
            cfg     <= '0;
            ie      <= '0;
            oe      <= '0;
            wr_err  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            idx     <= idx_d;
            timer   <= timer_d;
            ie_mask <= ie_mask_nxt;
            oe_mask <= oe_mask_nxt;
            cfg     <= cfg_nxt;
            ie      <= ie_d;
            oe      <= oe_d;
            wr_err  <= wr_bad;
            busy    <= (state_nxt == S_RAMP);
            done    <= (state_nxt == S_RUN);
        end
    end

endmodule

// File: tb/tb_la_ioseq.sv
// Scoreboard bench for la_ioseq (NPINS=4, CFGW=8, STEP=3): a cycle model pushes
// expected outputs before each edge; they are popped and compared just after it.
module tb_la_ioseq;

    localparam int unsigned NPINS = 4;
    localparam int unsigned CFGW  = 8;
    localparam int unsigned STEP  = 3;

    logic                  clk = 1'b0;
    logic                  nreset;
    logic                  pwrgood;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [7:0]            wr_addr;
    logic                  wr_ie;
    logic                  wr_oe;
    logic [CFGW-1:0]       wr_cfg;
    logic                  wr_err;
    logic [NPINS-1:0]      ie;
    logic [NPINS-1:0]      oe;
    logic [NPINS*CFGW-1:0] cfg;
    logic                  busy;
    logic                  done;

    la_ioseq #(.NPINS(NPINS), .CFGW(CFGW), .STEP(STEP)) dut (
        .clk(clk), .nreset(nreset), .pwrgood(pwrgood),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_ie(wr_ie), .wr_oe(wr_oe), .wr_cfg(wr_cfg), .wr_err(wr_err),
        .ie(ie), .oe(oe), .cfg(cfg), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPINS-1:0]      ie;
        logic [NPINS-1:0]      oe;
        logic [NPINS*CFGW-1:0] cfg;
        logic                  busy;
        logic                  done;
        logic                  err;
        logic                  rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: ramp progress kept as edges elapsed since RAMP entry.
    int                    m_state = 0;  // 0 off, 1 ramp, 2 run
    int                    m_k     = 0;
    logic [NPINS-1:0]      m_iem   = '0;
    logic [NPINS-1:0]      m_oem   = '0;
    logic [NPINS*CFGW-1:0] m_cfg   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    endtask

    task automatic model_push();
        exp_t e;
        logic [NPINS-1:0] rel;
        e.rdy = nreset;
        if (!nreset) begin
            m_state = 0; m_k = 0;
            m_iem = '0; m_oem = '0; m_cfg = '0;
            e.ie = '0; e.oe = '0; e.cfg = '0; e.err = 1'b0;
        end else begin
            e.err = wr_valid && (wr_addr >= 8'(NPINS));
            if (wr_valid && wr_addr < 8'(NPINS)) begin
                m_iem[wr_addr] = wr_ie;
                m_oem[wr_addr] = wr_oe;
                m_cfg[wr_addr*CFGW +: CFGW] = wr_cfg;
            end
            e.ie = '0; e.oe = '0;
            if (!pwrgood) begin
                m_state = 0;
            end else if (m_state == 0) begin
                m_state = 1; m_k = 0;
            end else if (m_state == 1) begin
                m_k++;
                for (int p = 0; p < int'(NPINS); p++) rel[p] = ((p + 1) * int'(STEP) <= m_k);
                e.ie = m_iem & rel;
                e.oe = m_oem & rel;
                if (m_k == int'(NPINS * STEP)) m_state = 2;
            end else begin
                e.ie = m_iem;
                e.oe = m_oem;
            end
            e.cfg = m_cfg;
        end
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        exp_q.push_back(e);
    endtask

    // One clock: push expectation, let the edge happen, pop and compare.
    task automatic cycle();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            check("ie",       64'(ie),       64'(e.ie));
            check("oe",       64'(oe),       64'(e.oe));
            check("cfg",      64'(cfg),      64'(e.cfg));
            check("busy",     64'(busy),     64'(e.busy));
            check("done",     64'(done),     64'(e.done));
            check("wr_err",   64'(wr_err),   64'(e.err));
            check("wr_ready", 64'(wr_ready), 64'(e.rdy));
        end
    endtask

    task automatic set_wr(input logic v, input logic [7:0] a, input logic i, input logic o,
                          input logic [CFGW-1:0] c);
        wr_valid = v; wr_addr = a; wr_ie = i; wr_oe = o; wr_cfg = c;
    endtask

    initial begin
        nreset = 1'b0; pwrgood = 1'b1;
        set_wr(1'b1, 8'd0, 1'b1, 1'b1, 8'hFF);
        @(negedge clk);

        // Reset overrides pwrgood and writes
        for (int i = 0; i < 2; i++) cycle();
        check("rst_ie", 64'(ie), 64'(0));
        check("rst_cfg", 64'(cfg), 64'(0));

        // Load all masks while power is down
        nreset = 1'b1; pwrgood = 1'b0;
        for (int p = 0; p < int'(NPINS); p++) begin
            set_wr(1'b1, 8'(p), 1'b1, 1'b1, 8'(8'h11 * (p + 1)));
            cycle();
        end
        set_wr(1'b0, 8'd0, 1'b0, 1'b0, 8'h00);

        // Full ramp
        pwrgood = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            cycle();
            if (i == 0)  check("t2_busy_c1", 64'(busy), 64'(1));
            if (i == 2)  check("t2_ie_c3", 64'(ie), 64'(0));
            if (i == 3)  check("t2_ie_c4", 64'(ie), 64'(4'b0001));
            if (i == 6)  check("t2_oe_c7", 64'(oe), 64'(4'b0011));
            if (i == 11) check("t2_done_c12", 64'(done), 64'(0));
            if (i == 12) check("t2_done_c13", 64'({busy, done, ie}), 64'({2'b01, 4'b1111}));
        end

        // Power loss mid-ramp, then re-raise
        pwrgood = 1'b0; cycle();
        pwrgood = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i == 8) pwrgood = 1'b0;
            cycle();
            if (i == 8) check("t3_drop", 64'({busy, ie, oe}), 64'(0));
        end
        pwrgood = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            cycle();
            if (i == 2) check("t3_re_c3", 64'(ie[0]), 64'(0));
            if (i == 3) check("t3_re_c4", 64'(ie[0]), 64'(1));
        end

        // Out-of-range write in RUN
        set_wr(1'b1, 8'd5, 1'b0, 1'b0, 8'h00);
        cycle();
        set_wr(1'b0, 8'd0, 1'b0, 1'b0, 8'h00);
        check("t4_err", 64'(wr_err), 64'(1));
        cycle();
        check("t4_err_clr", 64'(wr_err), 64'(0));
        check("t4_ie", 64'(ie), 64'(4'b1111));

        // RUN write takes effect the next cycle
        set_wr(1'b1, 8'd2, 1'b0, 1'b1, 8'hA5);
        cycle();
        set_wr(1'b0, 8'd0, 1'b0, 1'b0, 8'h00);
        check("t5_pin2", 64'({ie[2], oe[2], cfg[23:16]}), 64'({1'b0, 1'b1, 8'hA5}));
        cycle();

        // Mid-ramp write to a not-yet-released pin
        pwrgood = 1'b0; cycle();
        pwrgood = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i == 5) set_wr(1'b1, 8'd3, 1'b1, 1'b0, 8'h33);
            if (i == 6) set_wr(1'b0, 8'd0, 1'b0, 1'b0, 8'h00);
            cycle();
            if (i == 12) check("t6_pin3", 64'({ie[3], oe[3]}), 64'(2'b10));
            if (i == 16) check("t6_pin3_run", 64'(oe[3]), 64'(0));
        end

        // Random traffic with occasional power drops and a reset pulse
        for (int i = 0; i < 150; i++) begin
            pwrgood = ($urandom_range(0, 24) != 0);
            nreset  = (i != 70);
            set_wr(1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 5)),
                   1'($urandom), 1'($urandom), 8'($urandom));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
